// File: rtl/game_sequencer.sv
// Breakout game controller: walks IDLE -> SERVE -> PLAY -> GAME_OVER/WIN on
// frame timing, keeps lives and a saturating 4-digit BCD score.
module game_sequencer #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 120,
    parameter int HOLD_FRAMES  = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_pulse,
    input  logic        btn_select,
    input  logic        ball_lost,
    input  logic        block_hit,
    input  logic        all_cleared,
    output logic [2:0]  state,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        ball_hold,
    output logic        launch,
    output logic        field_reset,
    output logic        paddle_en
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        sel_q;
    logic        sel_edge;
    logic [7:0]  frame_cnt;
    logic        serve_done;
    logic        hold_done;

    logic [2:0]  lives_q;
    logic [2:0]  lives_d;
    logic [15:0] score_q;
    logic [15:0] score_d;
    logic        launch_q;
    logic        launch_d;
    logic        field_reset_q;
    logic        field_reset_d;
    logic        ball_hold_q;
    logic        ball_hold_d;
    logic        paddle_en_q;
    logic        paddle_en_d;

    // Digit-wise BCD increment; 9999 is the ceiling and does not wrap.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign sel_edge   = btn_select & ~sel_q;
    assign serve_done = frame_pulse && (frame_cnt == 8'(SERVE_FRAMES - 1));
    assign hold_done  = frame_pulse && (frame_cnt == 8'(HOLD_FRAMES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_edge) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (sel_edge || serve_done) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (all_cleared) begin
                    state_d = S_WIN;
                end else if (ball_lost) begin
                    state_d = (lives_q <= 3'd1) ? S_OVER : S_SERVE;
                end
            end
            S_OVER, S_WIN: begin
                if (hold_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        lives_d       = lives_q;
        score_d       = score_q;
        launch_d      = 1'b0;
        field_reset_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_edge) begin
                    lives_d       = 3'(LIVES);
                    score_d       = 16'h0000;
                    field_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (state_d == S_PLAY) launch_d = 1'b1;
            end
            S_PLAY: begin
                if (block_hit) score_d = bcd_inc(score_q);
                // A cleared field wins even if the ball drops in the same cycle.
                if (!all_cleared && ball_lost && lives_q != 3'd0) begin
                    lives_d = lives_q - 3'd1;
                end
            end
            default: ;
        endcase
        ball_hold_d = (state_d == S_SERVE);
        paddle_en_d = (state_d == S_SERVE) || (state_d == S_PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives_q       <= 3'd0;
            score_q       <= 16'h0000;
            launch_q      <= 1'b0;
            field_reset_q <= 1'b0;
            ball_hold_q   <= 1'b0;
            paddle_en_q   <= 1'b0;
        end else begin
            lives_q       <= lives_d;
            score_q       <= score_d;
            launch_q      <= launch_d;
            field_reset_q <= field_reset_d;
            ball_hold_q   <= ball_hold_d;
            paddle_en_q   <= paddle_en_d;
        end
    end

    // Button held through reset must not look like a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= 1'b1;
        end else begin
            sel_q <= btn_select;
        end
    end

    // Frame pulses landing on a state entry are dropped by the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (state_d != state_q) begin
            frame_cnt <= 8'd0;
        end else if (frame_pulse && frame_cnt != 8'hFF) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign ball_hold   = ball_hold_q;
    assign launch      = launch_q;
    assign field_reset = field_reset_q;
    assign paddle_en   = paddle_en_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: one linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_game_sequencer;

    logic        clk;
    logic        rst;
    logic        frame_pulse;
    logic        btn_select;
    logic        ball_lost;
    logic        block_hit;
    logic        all_cleared;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        ball_hold;
    logic        launch;
    logic        field_reset;
    logic        paddle_en;

    int checks = 0;
    int errors = 0;

    game_sequencer #(.LIVES(3), .SERVE_FRAMES(120), .HOLD_FRAMES(180)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_pulse (frame_pulse),
        .btn_select  (btn_select),
        .ball_lost   (ball_lost),
        .block_hit   (block_hit),
        .all_cleared (all_cleared),
        .state       (state),
        .lives       (lives),
        .score       (score),
        .ball_hold   (ball_hold),
        .launch      (launch),
        .field_reset (field_reset),
        .paddle_en   (paddle_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_select = 1'b1;
        tick();
        btn_select = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pulse = 1'b1;
            tick();
            frame_pulse = 1'b0;
            tick();
        end
    endtask

    task automatic hits(input int n);
        block_hit = 1'b1;
        repeat (n) tick();
        block_hit = 1'b0;
    endtask

    task automatic lose();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_select = 1'b1; frame_pulse = 1'b0;
        ball_lost = 1'b0; block_hit = 1'b0; all_cleared = 1'b0;
        repeat (3) tick();
        check("rst_state", 16'(state), 16'd0);
        check("rst_lives", 16'(lives), 16'd0);
        check("rst_score", score, 16'h0000);
        check("rst_strobes", {12'd0, ball_hold, launch, field_reset, paddle_en}, 16'd0);

        // Button held across reset release: no edge, stay IDLE.
        rst = 1'b0;
        repeat (4) tick();
        check("held_btn_idle", 16'(state), 16'd0);
        btn_select = 1'b0;
        tick();
        check("release_idle", 16'(state), 16'd0);

        press();
        check("start_state", 16'(state), 16'd1);
        check("start_lives", 16'(lives), 16'd3);
        check("start_score", score, 16'h0000);
        check("start_field_reset", 16'(field_reset), 16'd1);
        check("start_hold_paddle", {14'd0, ball_hold, paddle_en}, 16'd3);
        tick();
        check("field_reset_one_cycle", 16'(field_reset), 16'd0);

        // SERVE ignores ball_lost / block_hit.
        lose();
        block_hit = 1'b1; tick(); block_hit = 1'b0;
        check("serve_ignore_state", 16'(state), 16'd1);
        check("serve_ignore_lives", 16'(lives), 16'd3);
        check("serve_ignore_score", score, 16'h0000);

        frames(119);
        check("serve_119_state", 16'(state), 16'd1);
        check("serve_119_launch", 16'(launch), 16'd0);
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
        check("auto_launch_state", 16'(state), 16'd2);
        check("auto_launch_strobe", 16'(launch), 16'd1);
        check("auto_launch_hold", 16'(ball_hold), 16'd0);
        tick();
        check("launch_one_cycle", 16'(launch), 16'd0);

        // Score in BCD, then saturation at 9999.
        hits(9);
        check("score_0009", score, 16'h0009);
        hits(12);
        check("score_0021", score, 16'h0021);
        hits(9977);
        check("score_9998", score, 16'h9998);
        hits(3);
        check("score_9999_sat", score, 16'h9999);

        // Lives run down; select in PLAY is ignored.
        press();
        check("play_ignores_sel", 16'(state), 16'd2);
        tick();
        lose();
        check("lose1_state", 16'(state), 16'd1);
        check("lose1_lives", 16'(lives), 16'd2);
        tick();
        press();
        check("serve_btn_launch", {13'd0, state, launch}, {13'd0, 3'd2, 1'b1});
        lose();
        check("lose2_state", 16'(state), 16'd1);
        check("lose2_lives", 16'(lives), 16'd1);
        tick();
        press();
        lose();
        check("lose3_state", 16'(state), 16'd3);
        check("lose3_lives", 16'(lives), 16'd0);
        check("over_paddle", {14'd0, ball_hold, paddle_en}, 16'd0);
        tick();
        press();
        check("over_ignores_sel", 16'(state), 16'd3);
        frames(179);
        check("over_179", 16'(state), 16'd3);
        frames(1);
        check("over_to_idle", 16'(state), 16'd0);
        check("retained_score", score, 16'h9999);
        check("retained_lives", 16'(lives), 16'd0);

        // Simultaneous ball_lost, block_hit, all_cleared -> WIN.
        tick();
        press();
        check("game2_lives", 16'(lives), 16'd3);
        check("game2_score", score, 16'h0000);
        tick();
        press();
        check("game2_play", 16'(state), 16'd2);
        ball_lost = 1'b1; block_hit = 1'b1; all_cleared = 1'b1;
        tick();
        ball_lost = 1'b0; block_hit = 1'b0; all_cleared = 1'b0;
        check("win_state", 16'(state), 16'd4);
        check("win_lives", 16'(lives), 16'd3);
        check("win_score", score, 16'h0001);
        frames(180);
        check("win_to_idle", 16'(state), 16'd0);

        // Asynchronous reset mid-PLAY.
        tick();
        press();
        tick();
        press();
        hits(150);
        check("pre_rst_score", score, 16'h0150);
        check("pre_rst_state", 16'(state), 16'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 16'(state), 16'd0);
        check("async_rst_lives", 16'(lives), 16'd0);
        check("async_rst_score", score, 16'h0000);
        check("async_rst_strobes", {12'd0, ball_hold, launch, field_reset, paddle_en}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
